stat_accumulator: RTL and testbench
===================================

STAT_ACCUMULATOR -- requirements
Module: stat_accumulator

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 16, sample width (unsigned).
- ACC_W, default 64, accumulator width; ACC_W >= 2*DATA_W.
- WINDOW, default 256, samples per window; WINDOW >= 1.
REQ-002 Derived width CNT_W SHALL be clog2(WINDOW+1).
REQ-003 Ports SHALL be as follows; the design uses one clock, and reset is asynchronous and active-low:
- clk  in  1  rising-edge clock.
- nreset  in  1  asynchronous active-low reset.
- enable  in  1  0 = block idle and cleared.
- hold  in  1  1 = samples ignored.
- in_valid  in  1  data_in qualifier.
- data_in  in  DATA_W  sample.
- flush  in  1  close current window early.
- sum_out  out  ACC_W  window sum.
- sum_square_out  out  ACC_W  window sum of squares.
- count_out  out  CNT_W  samples in reported window.
- result_valid  out  1  one-cycle result strobe.
- overflow  out  1  saturation occurred in reported window.

Function
REQ-004 FSM SHALL have two states, IDLE and RUN: IDLE->RUN when enable=1; RUN->IDLE when enable=0.
REQ-005 A sample SHALL be accepted in cycle t iff state=RUN, enable=1, hold=0 and in_valid=1; in IDLE nothing is accepted.
REQ-006 Stage 1 SHALL register at edge t: the sample, its square (2*DATA_W bits, unsigned), a valid bit, and a flush bit (flush sampled under the same RUN/enable condition, independent of in_valid/hold).
REQ-007 Stage 2 SHALL, at edge t+1 when stage-1 valid=1, add the zero-extended sample to the running sum, add the zero-extended square to the running sum of squares, and increment the running count.
REQ-008 Each addition SHALL saturate to all-ones on carry-out of ACC_W and set the window overflow flag; sum and sum of squares saturate independently.
REQ-009 Window close SHALL occur at edge t+1 when the post-update count equals WINDOW or the stage-1 flush bit is 1.
REQ-010 On window close:
- sum_out, sum_square_out, count_out and overflow load the final window values, including the stage-1 sample if valid.
- result_valid=1 for exactly one cycle.
- Running sums, count and overflow flag clear to 0 with no carry into the next window.
REQ-011 Result latency SHALL be two edges: result_valid is high in the cycle after edge t+1 for an accepted sample or flush at cycle t.
REQ-012 A flush coincident with the WINDOW-th sample SHALL produce a single result.
REQ-013 A flush with an empty window SHALL produce result_valid with count_out=0, sums 0, overflow 0.
REQ-014 Output registers SHALL hold the last result until the next window close or clear.
REQ-015 hold=1 SHALL only block acceptance; a sample already in stage 1 still accumulates.
REQ-016 Samples SHALL be accepted back-to-back every cycle with no bubbles, including the cycle after a window close.
REQ-017 enable=0 SHALL, at the next edge, clear stage 1, running values and all outputs to 0 and discard any in-flight sample; no result is produced.
REQ-018 result_valid SHALL be 0 whenever enable was 0 at the previous edge.

Reset
REQ-019 nreset=0 SHALL asynchronously force state=IDLE and clear stage 1, running sums, count and overflow flag.
REQ-020 While nreset=0, all outputs SHALL be 0.
REQ-021 After nreset deasserts, the first sample SHALL be accepted no earlier than the cycle after the IDLE->RUN transition.
REQ-022 nreset asserted mid-window SHALL discard the partial window with no result_valid.

Verification (DATA_W=16, ACC_W=64, WINDOW=4 unless stated)
REQ-023 Samples 1,2,3,4 on consecutive cycles -> result_valid one cycle, 2 edges after sample 4; sum_out=10, sum_square_out=30, count_out=4, overflow=0.
REQ-024 Samples 5,_,hold-blocked 9,6,7,8 with gaps and hold pulses -> only 5,6,7,8 counted; sum_out=26, sum_square_out=174, count_out=4.
REQ-025 Samples 3,4 then flush alone -> sum_out=7, sum_square_out=25, count_out=2; the next window starts from 0.
REQ-026 With ACC_W=32, samples 0xFFFF x4 -> sum_out=0x3FFFC, sum_square_out=0xFFFFFFFF, overflow=1; the next window reports overflow=0.
REQ-027 Samples 1,2 then enable=0 for one cycle, then samples 1,1,1,1 -> no result from the first pair; result sum_out=4, count_out=4.
REQ-028 Samples 1,2,3 then nreset pulse mid-window -> all outputs 0 immediately, no result_valid; a subsequent full window reports correct values.

Source files
------------

// File: rtl/stat_accumulator.sv
// Windowed statistics accumulator.
// Accepted samples pass through a one-cycle register stage (sample, square,
// valid, flush) and are then folded into a running sum, sum of squares and
// count. A window closes when WINDOW samples have been accumulated or a flush
// reaches stage 2. On close, the final values are published on the output
// registers with a one-cycle result_valid strobe, and the running state
// restarts from zero.
module stat_accumulator #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 64,
    parameter int WINDOW = 256,
    localparam int CNT_W = $clog2(WINDOW + 1)
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              enable,
    input  logic              hold,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              flush,
    output logic [ACC_W-1:0]  sum_out,
    output logic [ACC_W-1:0]  sum_square_out,
    output logic [CNT_W-1:0]  count_out,
    output logic              result_valid,
    output logic              overflow
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] WINDOW_CNT = CNT_W'(WINDOW);

    state_t state_q, state_d;

    // Stage 1: registered sample, its square, and qualifiers
    logic [DATA_W-1:0]   s1_data_q,  s1_data_d;
    logic [2*DATA_W-1:0] s1_sq_q,    s1_sq_d;
    logic                s1_valid_q, s1_valid_d;
    logic                s1_flush_q, s1_flush_d;

    // Stage 2: running window state
    logic [ACC_W-1:0] run_sum_q, run_sum_d;
    logic [ACC_W-1:0] run_sq_q,  run_sq_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic             run_ovf_q, run_ovf_d;

    // Published result registers
    logic [ACC_W-1:0] sum_out_q,  sum_out_d;
    logic [ACC_W-1:0] sq_out_q,   sq_out_d;
    logic [CNT_W-1:0] cnt_out_q,  cnt_out_d;
    logic             ovf_out_q,  ovf_out_d;
    logic             rv_q,       rv_d;

    // Combinational helpers
    logic                accept;
    logic                flush_take;
    logic [2*DATA_W-1:0] data_wide;
    logic [2*DATA_W-1:0] data_square;
    logic [ACC_W:0]      sum_add;
    logic [ACC_W:0]      sq_add;
    logic [ACC_W-1:0]    sum_upd;
    logic [ACC_W-1:0]    sq_upd;
    logic [CNT_W-1:0]    cnt_upd;
    logic                ovf_upd;
    logic                window_close;

    // State register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: RUN follows enable with one edge of latency
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable)  state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Acceptance qualifiers; flush is independent of hold and in_valid
    assign accept     = (state_q == RUN) && enable && !hold && in_valid;
    assign flush_take = (state_q == RUN) && enable && flush;

    assign data_wide   = {{DATA_W{1'b0}}, data_in};
    assign data_square = data_wide * data_wide;

    // Stage 1 next values; unaccepted cycles load zeros so the stage is inert
    always_comb begin
        s1_data_d  = '0;
        s1_sq_d    = '0;
        s1_valid_d = 1'b0;
        s1_flush_d = 1'b0;
        if (accept) begin
            s1_data_d  = data_in;
            s1_sq_d    = data_square;
            s1_valid_d = 1'b1;
        end
        s1_flush_d = flush_take;
    end

    // Stage 1 registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s1_data_q  <= '0;
            s1_sq_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_flush_q <= 1'b0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_sq_q    <= s1_sq_d;
            s1_valid_q <= s1_valid_d;
            s1_flush_q <= s1_flush_d;
        end
    end

    // Saturating adds; the extra top bit is the carry-out of ACC_W
    assign sum_add = {1'b0, run_sum_q} + {1'b0, ACC_W'(s1_data_q)};
    assign sq_add  = {1'b0, run_sq_q}  + {1'b0, ACC_W'(s1_sq_q)};

    // Post-update window values, including the stage-1 sample when valid
    always_comb begin
        sum_upd = run_sum_q;
        sq_upd  = run_sq_q;
        cnt_upd = run_cnt_q;
        ovf_upd = run_ovf_q;
        if (s1_valid_q) begin
            sum_upd = sum_add[ACC_W] ? {ACC_W{1'b1}} : sum_add[ACC_W-1:0];
            sq_upd  = sq_add[ACC_W]  ? {ACC_W{1'b1}} : sq_add[ACC_W-1:0];
            cnt_upd = run_cnt_q + CNT_W'(1);
            ovf_upd = run_ovf_q | sum_add[ACC_W] | sq_add[ACC_W];
        end
    end

    // A full window and a coincident flush collapse into one close event
    assign window_close = s1_flush_q || (cnt_upd == WINDOW_CNT);

    // Stage 2 and output next values; enable low wipes everything
    always_comb begin
        run_sum_d = sum_upd;
        run_sq_d  = sq_upd;
        run_cnt_d = cnt_upd;
        run_ovf_d = ovf_upd;
        sum_out_d = sum_out_q;
        sq_out_d  = sq_out_q;
        cnt_out_d = cnt_out_q;
        ovf_out_d = ovf_out_q;
        rv_d      = 1'b0;
        if (!enable) begin
            run_sum_d = '0;
            run_sq_d  = '0;
            run_cnt_d = '0;
            run_ovf_d = 1'b0;
            sum_out_d = '0;
            sq_out_d  = '0;
            cnt_out_d = '0;
            ovf_out_d = 1'b0;
        end else if (window_close) begin
            sum_out_d = sum_upd;
            sq_out_d  = sq_upd;
            cnt_out_d = cnt_upd;
            ovf_out_d = ovf_upd;
            rv_d      = 1'b1;
            run_sum_d = '0;
            run_sq_d  = '0;
            run_cnt_d = '0;
            run_ovf_d = 1'b0;
        end
    end

    // Running window registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            run_sum_q <= '0;
            run_sq_q  <= '0;
            run_cnt_q <= '0;
            run_ovf_q <= 1'b0;
        end else begin
            run_sum_q <= run_sum_d;
            run_sq_q  <= run_sq_d;
            run_cnt_q <= run_cnt_d;
            run_ovf_q <= run_ovf_d;
        end
    end

    // Output registers hold the last result until the next close or clear
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sum_out_q <= '0;
            sq_out_q  <= '0;
            cnt_out_q <= '0;
            ovf_out_q <= 1'b0;
            rv_q      <= 1'b0;
        end else begin
            sum_out_q <= sum_out_d;
            sq_out_q  <= sq_out_d;
            cnt_out_q <= cnt_out_d;
            ovf_out_q <= ovf_out_d;
            rv_q      <= rv_d;
        end
    end

    assign sum_out        = sum_out_q;
    assign sum_square_out = sq_out_q;
    assign count_out      = cnt_out_q;
    assign overflow       = ovf_out_q;
    assign result_valid   = rv_q;

endmodule

// File: tb/tb_stat_accumulator.sv
// Randomized and directed bench for stat_accumulator. Two instances share the
// stimulus: one with a 64-bit accumulator and one with a 32-bit accumulator so
// saturation is reachable. Expected values come from a window-list model that
// sums the accepted samples with plain arithmetic when a window closes.
module tb_stat_accumulator;

    localparam int DATA_W = 16;
    localparam int WINDOW = 4;
    localparam int CNT_W  = $clog2(WINDOW + 1);

    logic              clk;
    logic              nreset;
    logic              enable;
    logic              hold;
    logic              in_valid;
    logic [DATA_W-1:0] data_in;
    logic              flush;

    logic [63:0]      sum64, sq64;
    logic [CNT_W-1:0] cnt64;
    logic             rv64, ovf64;
    logic [31:0]      sum32, sq32;
    logic [CNT_W-1:0] cnt32;
    logic             rv32, ovf32;

    stat_accumulator #(.DATA_W(DATA_W), .ACC_W(64), .WINDOW(WINDOW)) u_dut64 (
        .clk(clk), .nreset(nreset), .enable(enable), .hold(hold),
        .in_valid(in_valid), .data_in(data_in), .flush(flush),
        .sum_out(sum64), .sum_square_out(sq64), .count_out(cnt64),
        .result_valid(rv64), .overflow(ovf64)
    );

    stat_accumulator #(.DATA_W(DATA_W), .ACC_W(32), .WINDOW(WINDOW)) u_dut32 (
        .clk(clk), .nreset(nreset), .enable(enable), .hold(hold),
        .in_valid(in_valid), .data_in(data_in), .flush(flush),
        .sum_out(sum32), .sum_square_out(sq32), .count_out(cnt32),
        .result_valid(rv32), .overflow(ovf32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int unsigned win[$];
    bit          m_run;
    bit          p_valid;
    int unsigned p_data;
    bit          p_flush;

    logic [63:0] exp_sum64, exp_sq64, exp_sum32, exp_sq32;
    logic        exp_ovf64, exp_ovf32, exp_rv;
    int unsigned exp_cnt;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_clear();
        win.delete();
        p_valid   = 1'b0;
        p_data    = 0;
        p_flush   = 1'b0;
        exp_sum64 = '0;
        exp_sq64  = '0;
        exp_sum32 = '0;
        exp_sq32  = '0;
        exp_ovf64 = 1'b0;
        exp_ovf32 = 1'b0;
        exp_rv    = 1'b0;
        exp_cnt   = 0;
    endtask

    // Totals are exact; saturation means clamping to the accumulator maximum,
    // and the overflow flag means the exact total exceeded that maximum.
    task automatic close_window();
        logic [127:0] tot_s, tot_q;
        logic [127:0] max64, max32;
        tot_s = '0;
        tot_q = '0;
        max64 = 128'hFFFF_FFFF_FFFF_FFFF;
        max32 = 128'hFFFF_FFFF;
        foreach (win[i]) begin
            tot_s += 128'(win[i]);
            tot_q += 128'(win[i]) * 128'(win[i]);
        end
        exp_sum64 = (tot_s > max64) ? 64'hFFFF_FFFF_FFFF_FFFF : tot_s[63:0];
        exp_sq64  = (tot_q > max64) ? 64'hFFFF_FFFF_FFFF_FFFF : tot_q[63:0];
        exp_ovf64 = (tot_s > max64) || (tot_q > max64);
        exp_sum32 = (tot_s > max32) ? 64'hFFFF_FFFF : {32'd0, tot_s[31:0]};
        exp_sq32  = (tot_q > max32) ? 64'hFFFF_FFFF : {32'd0, tot_q[31:0]};
        exp_ovf32 = (tot_s > max32) || (tot_q > max32);
        exp_cnt   = win.size();
        exp_rv    = 1'b1;
        $display("result cnt=%0d sum=%0h sumsq=%0h ovf64=%0b sum32=%0h sumsq32=%0h ovf32=%0b",
                 exp_cnt, exp_sum64, exp_sq64, exp_ovf64, exp_sum32, exp_sq32, exp_ovf32);
        win.delete();
    endtask

    // Model behaviour at one rising edge, using the inputs present at that edge
    task automatic model_edge();
        if (!enable) begin
            model_clear();
        end else begin
            exp_rv = 1'b0;
            if (p_valid) win.push_back(p_data);
            if (p_flush || win.size() == WINDOW) close_window();
            p_valid = m_run && in_valid && !hold;
            p_data  = p_valid ? 32'(data_in) : 0;
            p_flush = m_run && flush;
        end
        m_run = enable;
    endtask

    task automatic compare_all();
        check_val("rv64",  {63'd0, rv64},  {63'd0, exp_rv});
        check_val("rv32",  {63'd0, rv32},  {63'd0, exp_rv});
        check_val("cnt64", 64'(cnt64),     64'(exp_cnt));
        check_val("cnt32", 64'(cnt32),     64'(exp_cnt));
        check_val("sum64", sum64,          exp_sum64);
        check_val("sq64",  sq64,           exp_sq64);
        check_val("ovf64", {63'd0, ovf64}, {63'd0, exp_ovf64});
        check_val("sum32", {32'd0, sum32}, exp_sum32);
        check_val("sq32",  {32'd0, sq32},  exp_sq32);
        check_val("ovf32", {63'd0, ovf32}, {63'd0, exp_ovf32});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drv(input bit en, input bit hd, input bit vld,
                       input int unsigned d, input bit fl);
        enable   = en;
        hold     = hd;
        in_valid = vld;
        data_in  = DATA_W'(d);
        flush    = fl;
        cycle();
    endtask

    task automatic sample(input int unsigned d);
        drv(1'b1, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(1'b1, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic pulse_reset();
        #2;
        nreset = 1'b0;
        #1;
        m_run = 1'b0;
        model_clear();
        compare_all();
        #1;
        nreset = 1'b1;
    endtask

    initial begin
        nreset   = 1'b0;
        enable   = 1'b0;
        hold     = 1'b0;
        in_valid = 1'b0;
        data_in  = '0;
        flush    = 1'b0;
        m_run    = 1'b0;
        model_clear();

        // Outputs held at zero while reset is asserted, even across edges
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        nreset = 1'b1;

        // Enable with a sample on the transition cycle: it must be ignored
        drv(1'b1, 1'b0, 1'b1, 77, 1'b0);

        // 1,2,3,4 back-to-back
        sample(1); sample(2); sample(3); sample(4);
        idle(3);

        // 5, gap, hold-blocked 9, 6, hold pulse, 7, 8
        sample(5);
        idle(1);
        drv(1'b1, 1'b1, 1'b1, 9, 1'b0);
        sample(6);
        drv(1'b1, 1'b1, 1'b1, 1000, 1'b0);
        sample(7); sample(8);
        idle(3);

        // 3,4 then flush alone, then a fresh window
        sample(3); sample(4);
        drv(1'b1, 1'b0, 1'b0, 0, 1'b1);
        idle(2);

        // Flush on an empty window
        drv(1'b1, 1'b0, 0, 0, 1'b1);
        idle(2);

        // Flush coincident with the fourth sample: one result only
        sample(10); sample(20); sample(30);
        drv(1'b1, 1'b0, 1'b1, 40, 1'b1);
        idle(3);

        // Saturation in the 32-bit instance, then a clean window
        sample(16'hFFFF); sample(16'hFFFF); sample(16'hFFFF); sample(16'hFFFF);
        sample(1); sample(1); sample(1); sample(1);
        idle(3);

        // Eight samples back-to-back across a window boundary
        for (int i = 1; i <= 8; i++) sample(i * 100);
        idle(3);

        // 1,2 then enable low for one cycle, then 1,1,1,1
        sample(1); sample(2);
        drv(1'b0, 1'b0, 1'b0, 0, 1'b0);
        drv(1'b1, 1'b0, 1'b0, 0, 1'b0);
        sample(1); sample(1); sample(1); sample(1);
        idle(3);

        // 1,2,3 then a mid-window reset pulse, then a full window
        sample(1); sample(2); sample(3);
        pulse_reset();
        idle(3);
        drv(1'b1, 1'b0, 1'b0, 0, 1'b0);
        sample(11); sample(12); sample(13); sample(14);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            bit          en, hd, vl, fl;
            int unsigned d;
            en = ($urandom_range(0, 99) < 96);
            hd = ($urandom_range(0, 99) < 20);
            vl = ($urandom_range(0, 99) < 75);
            fl = ($urandom_range(0, 99) < 8);
            d  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 65535)
                                             : $urandom_range(0, 15);
            drv(en, hd, vl, d, fl);
            if ($urandom_range(0, 199) == 0) pulse_reset();
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
